// File: rtl/tdpu_acc_requant_pkg.sv
// Shared widths, activation range and FSM encoding for the TDPU accumulate/requantize stage.
package tdpu_acc_requant_pkg;
    localparam int PSUM_W  = 32;
    localparam int ACC_W   = 48;
    localparam int CNT_W   = 16;
    localparam int SCALE_W = 16;
    localparam int OUT_W   = 8;

    localparam int ACT_MAX = 127;
    localparam int ACT_MIN = -128;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SCALE, ST_OUTPUT} acc_state_t;
endpackage

// File: rtl/tdpu_acc_requant_requant_unit.sv
// Combinational requantizer: acc * scale, round-half-up arithmetic shift, clamp to the activation range.
module requant_unit
    import tdpu_acc_requant_pkg::*;
#(
    parameter int A_W = ACC_W,
    parameter int S_W = SCALE_W,
    parameter int O_W = OUT_W
) (
    input  logic signed [A_W-1:0] acc,
    input  logic        [S_W-1:0] scale,
    input  logic        [4:0]     shift,
    output logic signed [O_W-1:0] data,
    output logic                  sat
);
    localparam int PROD_W = A_W + S_W + 1;

    logic signed [S_W:0]      scale_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd;
    logic signed [PROD_W-1:0] shr;

    always_comb begin
        scale_s = {1'b0, scale};
        prod    = PROD_W'(acc) * PROD_W'(scale_s);
        rnd     = '0;
        if (shift != 5'd0)
            rnd = PROD_W'(1) << (shift - 5'd1);
        shr  = (prod + rnd) >>> shift;
        sat  = 1'b0;
        data = shr[O_W-1:0];
        if (shr > PROD_W'(ACT_MAX)) begin
            data = O_W'(ACT_MAX);
            sat  = 1'b1;
        end else if (shr < PROD_W'(ACT_MIN)) begin
            data = O_W'(ACT_MIN);
            sat  = 1'b1;
        end
    end
endmodule

// File: rtl/tdpu_acc_requant.sv
// Accumulates N partial sums per group, requantizes the total to a signed activation
// and hands it downstream over valid/ready.
module tdpu_acc_requant
    import tdpu_acc_requant_pkg::*;
#(
    parameter int P_W = PSUM_W,
    parameter int A_W = ACC_W,
    parameter int C_W = CNT_W,
    parameter int S_W = SCALE_W,
    parameter int O_W = OUT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic        [C_W-1:0] i_cfg_chunks,
    input  logic        [S_W-1:0] i_cfg_scale,
    input  logic        [4:0]     i_cfg_shift,
    input  logic                  i_psum_valid,
    input  logic signed [P_W-1:0] i_psum,
    output logic                  o_psum_ready,
    output logic                  o_out_valid,
    output logic signed [O_W-1:0] o_out_data,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_sat,
    input  logic                  i_sat_clr
);
    acc_state_t             state, state_nxt;
    logic signed [A_W-1:0]  acc;
    logic        [C_W-1:0]  cnt, cnt_inc, n_lat, n_first;
    logic        [S_W-1:0]  scale_lat;
    logic        [4:0]      shift_lat;
    logic                   beat;
    logic signed [O_W-1:0]  rq_data;
    logic                   rq_sat;

    assign beat    = i_psum_valid & o_psum_ready;
    assign cnt_inc = cnt + C_W'(1);
    // A zero chunk count would never terminate the group, so it behaves as one.
    assign n_first = (i_cfg_chunks == '0) ? C_W'(1) : i_cfg_chunks;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (beat) state_nxt = (n_first == C_W'(1)) ? ST_SCALE : ST_ACCUM;
            ST_ACCUM:  if (beat && cnt_inc == n_lat) state_nxt = ST_SCALE;
            ST_SCALE:  state_nxt = ST_OUTPUT;
            ST_OUTPUT: if (i_out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    requant_unit #(.A_W(A_W), .S_W(S_W), .O_W(O_W)) u_requant (
        .acc   (acc),
        .scale (scale_lat),
        .shift (shift_lat),
        .data  (rq_data),
        .sat   (rq_sat)
    );

    // Ready is registered from the next state so it stays low through reset
    // and rises on the first edge after release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_psum_ready <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            n_lat        <= '0;
            scale_lat    <= '0;
            shift_lat    <= '0;
            o_out_data   <= '0;
            o_sat        <= 1'b0;
        end else begin
            o_psum_ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_ACCUM);
            case (state)
                ST_IDLE: if (beat) begin
                    acc       <= A_W'(i_psum);
                    cnt       <= C_W'(1);
                    n_lat     <= n_first;
                    scale_lat <= i_cfg_scale;
                    shift_lat <= i_cfg_shift;
                end
                ST_ACCUM: if (beat) begin
                    acc <= acc + A_W'(i_psum);
                    cnt <= cnt_inc;
                end
                ST_SCALE: o_out_data <= rq_data;
                default: ;
            endcase
            if (state == ST_SCALE && rq_sat) o_sat <= 1'b1;
            else if (i_sat_clr)              o_sat <= 1'b0;
        end
    end

    assign o_out_valid = (state == ST_OUTPUT);
    assign o_busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_tdpu_acc_requant.sv
// Directed bench for tdpu_acc_requant: hand-computed groups, backpressure, config edge cases, mid-group reset.
module tb_tdpu_acc_requant;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        cfg_chunks = '0;
    logic [15:0]        cfg_scale = '0;
    logic [4:0]         cfg_shift = '0;
    logic               psum_valid = 1'b0;
    logic signed [31:0] psum = '0;
    logic               psum_ready;
    logic               out_valid;
    logic signed [7:0]  out_data;
    logic               out_ready = 1'b0;
    logic               busy;
    logic               sat;
    logic               sat_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    tdpu_acc_requant dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_chunks (cfg_chunks),
        .i_cfg_scale  (cfg_scale),
        .i_cfg_shift  (cfg_shift),
        .i_psum_valid (psum_valid),
        .i_psum       (psum),
        .o_psum_ready (psum_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .i_out_ready  (out_ready),
        .o_busy       (busy),
        .o_sat        (sat),
        .i_sat_clr    (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends nb beats, checks the SCALE bubble, the result, optional backpressure, then handshakes.
    task automatic run_group(input string tag, input int n_cfg, input int scale, input int shift,
                             input int vals[4], input int nb, input int exp, input logic exp_sat,
                             input int hold, input bit chg);
        cfg_chunks = 16'(n_cfg);
        cfg_scale  = 16'(scale);
        cfg_shift  = 5'(shift);
        for (int i = 0; i < nb; i++) begin
            chk({tag, ".rdy"}, 8'(psum_ready), 8'd1);
            psum_valid = 1'b1;
            psum       = 32'(vals[i]);
            @(posedge clk); #1;
            if (i == 0 && chg) begin
                cfg_chunks = 16'd1;
                cfg_scale  = 16'd2;
                cfg_shift  = 5'd3;
            end
        end
        psum_valid = 1'b0;
        chk({tag, ".scl_vld"}, 8'(out_valid), 8'd0);
        chk({tag, ".scl_rdy"}, 8'(psum_ready), 8'd0);
        chk({tag, ".scl_busy"}, 8'(busy), 8'd1);
        @(posedge clk); #1;
        chk({tag, ".vld"}, 8'(out_valid), 8'd1);
        chk({tag, ".data"}, 8'(out_data), 8'(exp));
        chk({tag, ".sat"}, 8'(exp_sat), 8'(sat));
        for (int h = 0; h < hold; h++) begin
            chk({tag, ".bp_rdy"}, 8'(psum_ready), 8'd0);
            psum_valid = 1'b1;
            psum       = 32'sd99;
            @(posedge clk); #1;
            chk({tag, ".bp_vld"}, 8'(out_valid), 8'd1);
            chk({tag, ".bp_data"}, 8'(out_data), 8'(exp));
        end
        psum_valid = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".done_vld"}, 8'(out_valid), 8'd0);
        chk({tag, ".done_busy"}, 8'(busy), 8'd0);
        chk({tag, ".done_rdy"}, 8'(psum_ready), 8'd1);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst.vld", 8'(out_valid), 8'd0);
        chk("rst.data", 8'(out_data), 8'd0);
        chk("rst.sat", 8'(sat), 8'd0);
        chk("rst.busy", 8'(busy), 8'd0);
        chk("rst.rdy", 8'(psum_ready), 8'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rel.rdy", 8'(psum_ready), 8'd1);

        // 10-3+7-2 = 12
        run_group("t1", 4, 1, 0, '{10, -3, 7, -2}, 4, 12, 1'b0, 0, 1'b0);
        // (15+2)>>2 = 4 ; (-15+2)>>>2 = -4
        run_group("t2a", 2, 3, 2, '{5, 0, 0, 0}, 2, 4, 1'b0, 0, 1'b0);
        run_group("t2b", 2, 3, 2, '{-5, 0, 0, 0}, 2, -4, 1'b0, 0, 1'b0);
        // 850*300 = 255000; (255000+2048)>>12 = 62
        run_group("t2c", 3, 300, 12, '{1000, -200, 50, 0}, 3, 62, 1'b0, 0, 1'b0);
        // 200*1000 clamps high
        run_group("t3a", 1, 1000, 0, '{200, 0, 0, 0}, 1, 127, 1'b1, 0, 1'b0);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("t3.clr", 8'(sat), 8'd0);
        run_group("t3b", 1, 1000, 0, '{-200, 0, 0, 0}, 1, -128, 1'b1, 0, 1'b0);
        // backpressure: result held 5 cycles, the offered 99 is not taken
        run_group("t4", 1, 1, 0, '{50, 0, 0, 0}, 1, 50, 1'b1, 5, 1'b0);
        run_group("t4n", 1, 1, 0, '{-7, 0, 0, 0}, 1, -7, 1'b1, 0, 1'b0);
        // chunks=0 acts as 1
        run_group("t5a", 0, 1, 0, '{33, 0, 0, 0}, 1, 33, 1'b1, 0, 1'b0);
        // config change after first beat ignored: 1+2+3 with scale 1, shift 0
        run_group("t5b", 3, 1, 0, '{1, 2, 3, 0}, 3, 6, 1'b1, 0, 1'b1);

        // reset mid-group after 2 of 4 beats
        cfg_chunks = 16'd4;
        cfg_scale  = 16'd1;
        cfg_shift  = 5'd0;
        for (int i = 0; i < 2; i++) begin
            psum_valid = 1'b1;
            psum       = 32'sd100;
            @(posedge clk); #1;
        end
        psum_valid = 1'b0;
        chk("t6.pre_busy", 8'(busy), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6.vld", 8'(out_valid), 8'd0);
        chk("t6.data", 8'(out_data), 8'd0);
        chk("t6.sat", 8'(sat), 8'd0);
        chk("t6.busy", 8'(busy), 8'd0);
        chk("t6.rdy", 8'(psum_ready), 8'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("t6.rel_rdy", 8'(psum_ready), 8'd1);
        run_group("t6n", 4, 1, 0, '{1, 2, 3, 4}, 4, 10, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end
endmodule
